user_flash_cached: RTL and testbench
====================================

# user_flash_cached

Parametrised successor to the writable flash mock. It is a memory-mapped user-flash model with a direct-mapped read cache and configurable backing-array read latency, and it drives real `cache_hit`/`cache_miss` strobes. It sits on the PicoRV native memory bus behind the address decoder, in the same slot as the existing flash. Writes from the bootloader go through to the backing array.

## Interface
- `ADDR_WIDTH`, 17: byte-address width; word address is `addr[ADDR_WIDTH-1:2]`.
- `LINES`, 16: cache lines; power of 2, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of 2, ≥1.
- `FLASH_LATENCY`, 4: cycles per backing-array word read during a fill; ≥1.
- `WRITABLE`, 1: 1 = writes update the array; 0 = writes are acknowledged and dropped.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `reset_n` in 1: async active-low reset.
- `select` in 1: request valid; held until `ready` is seen.
- `wstrb` in 4: byte enables; 0 = read.
- `addr` in ADDR_WIDTH: byte address.
- `data_i` in 32: write data.
- `cache_flush` in 1: single-cycle pulse; invalidates all lines.
- `ready` out 1: one-cycle acknowledge pulse.
- `data_o` out 32: read data, valid while `ready`=1.
- `cache_hit` out 1: one-cycle pulse on a read hit.
- `cache_miss` out 1: one-cycle pulse on a read miss.

## Operation
- Address split:
  - `OFF_W = clog2(WORDS_PER_LINE)`, `IDX_W = clog2(LINES)`, `TAG_W = ADDR_WIDTH-2-OFF_W-IDX_W`.
  - Offset is `addr[2+:OFF_W]`, index is the next `IDX_W` bits, tag is the rest.
  - `addr[1:0]` is ignored.
- Storage:
  - Backing array holds `2^(ADDR_WIDTH-2)` words, zero-initialised at elaboration and not reset.
  - Cache holds a data array, a tag array and a valid bit per line; valid bits live in flops.
- FSM states:
  - IDLE: accepts a request.
  - FILL: line refill; word counter `0..WORDS_PER_LINE-1`, latency counter `0..FLASH_LATENCY-1`.
  - DONE: `ready` high; `select` ignored.
  - DONE always returns to IDLE.
- Read hit: IDLE → DONE; `data_o` = cached word; `cache_hit`=1 during DONE.
- Read miss:
  - IDLE → FILL; `cache_miss`=1 for the first FILL cycle.
  - Words are fetched in ascending order from offset 0; each word is written into the line after `FLASH_LATENCY` cycles.
  - After the last word: tag is written, valid set, `data_o` = requested word, → DONE.
- Write (`wstrb`≠0), from IDLE:
  - If `WRITABLE`, byte-merge into the backing array.
  - If the line is valid and the tag matches, byte-merge into the cached word (write-through, no allocate).
  - → DONE. No hit/miss pulse. `data_o` holds its previous value.
- Flush:
  - `cache_flush` clears all valid bits at the next edge, in any state.
  - Same cycle as a read in IDLE: the lookup sees cleared valids, so it is a miss.
  - During FILL: the fill completes and returns data, but the line is not marked valid.

## Timing
- Reset values: `ready`=0, `data_o`=0, `cache_hit`=0, `cache_miss`=0, all valid=0, state IDLE.
- Reset asserted mid-FILL aborts the fill; no `ready` is issued.
- Latency, counting the edge that samples `select` in IDLE as edge 0:
  - Hit read and write: `ready` high after edge 1.
  - Miss: `ready` high after edge `WORDS_PER_LINE*FLASH_LATENCY + 1` (17 at defaults).
- `ready` is high for exactly one cycle. DONE ignores `select`, so a master that drops `select` at the edge where it samples `ready` never starts a duplicate transaction.
- `select` deasserted in FILL does not abort; completion is still acknowledged.
- `addr`, `wstrb` and `data_i` must stay stable while `select`=1.

## Structure
- Shared package `user_flash_pkg`:
  - state encoding localparams (IDLE, FILL, DONE);
  - `clog2`-derived width constants `OFF_W`, `IDX_W`, `TAG_W`.
- Sub-module `user_flash_array`: backing word array with byte-merge write port and registered read port.
- The top holds the FSM, counters, tag/valid/data arrays and output registers.

## Test plan
- Write 0xDEADBEEF to 0x40, `wstrb`=F → `ready` at edge 1. Read 0x40 → `cache_miss` pulse, `ready` at edge 17, `data_o`=0xDEADBEEF. Read 0x44 → `cache_hit`, `ready` at edge 1, `data_o`=0.
- With 0x40 cached, write 0x0000AA00, `wstrb`=0010 → read 0x40 hits and returns 0xDEADAAEF.
- Alternate reads 0x40 and 0x140 (same index, different tag) → every access misses; each returns its own written data.
- Start a miss at 0x80 and pulse `cache_flush` at edge 5 → `ready` at edge 17 with correct data; re-read 0x80 misses.
- Assert `reset_n`=0 during FILL → `ready` stays 0; all outputs 0; the next read of the same address misses.
- Hold `select` high one cycle past `ready`, then drop it → exactly one `ready` pulse per request.

Source files
------------

// File: rtl/user_flash_pkg.sv
// ---------------------------------------------------------------------------
// user_flash_pkg
//   Shared definitions for the cached user-flash model.
//   - state_t : FSM state encoding (IDLE, FILL, DONE)
//   - clog2   : elaboration-time ceiling log2 helper
//   - OFF_W / IDX_W / TAG_W : address-split widths for the default geometry
//     (17-bit byte address, 16 lines, 4 words per line)
// ---------------------------------------------------------------------------
package user_flash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEFAULT_ADDR_WIDTH     = 17;
  localparam int DEFAULT_LINES          = 16;
  localparam int DEFAULT_WORDS_PER_LINE = 4;

  localparam int OFF_W = clog2(DEFAULT_WORDS_PER_LINE);
  localparam int IDX_W = clog2(DEFAULT_LINES);
  localparam int TAG_W = DEFAULT_ADDR_WIDTH - 2 - OFF_W - IDX_W;

endpackage

// File: rtl/user_flash_array.sv
// ---------------------------------------------------------------------------
// user_flash_array
//   Backing word array of the user flash. Zero-initialised at elaboration,
//   never reset. One byte-enabled write port and one registered read port.
//   Ports:
//     clk    in  : clock
//     we     in  : write enable (ignored when WRITABLE = 0)
//     wstrb  in  : byte enables for the write
//     waddr  in  : word address for the write
//     wdata  in  : write data
//     raddr  in  : word address for the read
//     rdata  out : mem[raddr] as sampled at the previous clock edge
// ---------------------------------------------------------------------------
module user_flash_array #(
  parameter int ADDR_WIDTH = 17,
  parameter int WRITABLE   = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-3:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-3:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  // Byte-lane writes keep the array mappable onto byte-enabled block RAM.
  always_ff @(posedge clk) begin
    if ((WRITABLE != 0) && we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/user_flash_cached.sv
// ---------------------------------------------------------------------------
// user_flash_cached
//   Memory-mapped user flash with a direct-mapped, write-through,
//   no-write-allocate read cache in front of a slow backing array.
//   A request is latched in IDLE, looked up one cycle later, then either
//   acknowledged directly (hit / write) or refilled word by word (miss).
//   Ports:
//     clk         in  : clock
//     reset_n     in  : asynchronous active-low reset
//     select      in  : request valid, held until ready
//     wstrb       in  : byte enables, 0 = read
//     addr        in  : byte address (addr[1:0] ignored)
//     data_i      in  : write data
//     cache_flush in  : pulse, invalidates every line
//     ready       out : one-cycle acknowledge
//     data_o      out : read data, valid while ready
//     cache_hit   out : one-cycle pulse on a read hit
//     cache_miss  out : one-cycle pulse on a read miss (first FILL cycle)
// ---------------------------------------------------------------------------
module user_flash_cached
  import user_flash_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int FLASH_LATENCY  = 4,
  parameter int WRITABLE       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  select,
  input  logic [3:0]            wstrb,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_i,
  input  logic                  cache_flush,
  output logic                  ready,
  output logic [31:0]           data_o,
  output logic                  cache_hit,
  output logic                  cache_miss
);

  localparam int WA_W        = ADDR_WIDTH - 2;
  localparam int OFF_BITS    = clog2(WORDS_PER_LINE);
  localparam int IDX_BITS    = clog2(LINES);
  localparam int TAG_BITS    = WA_W - OFF_BITS - IDX_BITS;
  localparam int PTR_W       = IDX_BITS + OFF_BITS;
  localparam int WCNT_W      = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int LCNT_W      = (clog2(FLASH_LATENCY) > 0) ? clog2(FLASH_LATENCY) : 1;
  localparam int CACHE_WORDS = LINES * WORDS_PER_LINE;

  localparam logic [WA_W-1:0]   OFF_MASK  = WA_W'(WORDS_PER_LINE - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS_PER_LINE - 1);
  localparam logic [LCNT_W-1:0] LAT_LAST  = LCNT_W'(FLASH_LATENCY - 1);

  state_t state, state_next;

  logic                pending;
  logic [WA_W-1:0]     req_word;
  logic [3:0]          req_wstrb;
  logic [31:0]         req_data;
  logic [WCNT_W-1:0]   word_cnt;
  logic [LCNT_W-1:0]   lat_cnt;
  logic                fill_flushed;
  logic [LINES-1:0]    valid;

  logic [TAG_BITS-1:0] tag_mem    [LINES];
  logic [31:0]         cache_data [CACHE_WORDS];

  logic [WCNT_W-1:0]   req_off;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [PTR_W-1:0]    req_ptr;
  logic [PTR_W-1:0]    fill_ptr;
  logic [WCNT_W-1:0]   next_word;
  logic [WA_W-1:0]     array_raddr;
  logic [31:0]         array_rdata;

  logic lookup, is_write, line_match, read_hit, read_miss;
  logic word_last, lat_last, fill_end;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  assign req_off  = WCNT_W'(req_word & OFF_MASK);
  assign req_idx  = IDX_BITS'(req_word >> OFF_BITS);
  assign req_tag  = TAG_BITS'(req_word >> (OFF_BITS + IDX_BITS));
  assign req_ptr  = (PTR_W'(req_idx) << OFF_BITS) | PTR_W'(req_off);
  assign fill_ptr = (PTR_W'(req_idx) << OFF_BITS) | PTR_W'(word_cnt);

  // The lookup happens in the IDLE cycle after the request is latched, so a
  // flush pulse in either IDLE cycle forces a miss.
  assign lookup     = (state == IDLE) && pending;
  assign is_write   = (req_wstrb != 4'b0000);
  assign line_match = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign read_hit   = lookup && !is_write && line_match && !cache_flush;
  assign read_miss  = lookup && !is_write && !read_hit;

  assign word_last = (word_cnt == WORD_LAST);
  assign lat_last  = (lat_cnt == LAT_LAST);
  assign fill_end  = (state == FILL) && word_last && lat_last;

  // The array read is issued one cycle ahead of use: on the last latency
  // cycle of a word the address already points at the next word, so the
  // registered read data always belongs to the word currently being filled.
  always_comb begin
    next_word = '0;
    if (state == FILL) next_word = lat_last ? (word_cnt + WCNT_W'(1)) : word_cnt;
  end

  assign array_raddr = (req_word & ~OFF_MASK) | (WA_W'(next_word) & OFF_MASK);

  user_flash_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WRITABLE   (WRITABLE)
  ) u_array (
    .clk   (clk),
    .we    (lookup && is_write),
    .wstrb (req_wstrb),
    .waddr (req_word),
    .wdata (req_data),
    .raddr (array_raddr),
    .rdata (array_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lookup) state_next = (is_write || read_hit) ? DONE : FILL;
      FILL:    if (word_last && lat_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, fill counters and valid bits. The request is latched so
  // a master may drop select during a fill without disturbing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= 1'b0;
      req_word     <= '0;
      req_wstrb    <= '0;
      req_data     <= '0;
      word_cnt     <= '0;
      lat_cnt      <= '0;
      fill_flushed <= 1'b0;
      valid        <= '0;
    end else begin
      if ((state == IDLE) && !pending && select) begin
        pending   <= 1'b1;
        req_word  <= addr[ADDR_WIDTH-1:2];
        req_wstrb <= wstrb;
        req_data  <= data_i;
      end else if (lookup) begin
        pending <= 1'b0;
      end

      if (read_miss) begin
        word_cnt     <= '0;
        lat_cnt      <= '0;
        fill_flushed <= 1'b0;
      end else if (state == FILL) begin
        if (cache_flush) fill_flushed <= 1'b1;
        if (lat_last) begin
          lat_cnt  <= '0;
          word_cnt <= word_cnt + WCNT_W'(1);
        end else begin
          lat_cnt <= lat_cnt + LCNT_W'(1);
        end
      end

      // A flush anywhere in the fill leaves the refilled line invalid.
      if (cache_flush)                   valid          <= '0;
      else if (fill_end && !fill_flushed) valid[req_idx] <= 1'b1;
    end
  end

  // Cache data and tag storage; contents are qualified by valid, so no reset.
  always_ff @(posedge clk) begin
    if ((state == FILL) && lat_last) cache_data[fill_ptr] <= array_rdata;
    if (fill_end) tag_mem[req_idx] <= req_tag;
    if (lookup && is_write && line_match) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) cache_data[req_ptr][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  // Registered outputs; ready and the strobes are high only for the DONE
  // cycle (ready, cache_hit) or the first FILL cycle (cache_miss).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready      <= 1'b0;
      data_o     <= '0;
      cache_hit  <= 1'b0;
      cache_miss <= 1'b0;
    end else begin
      ready      <= (lookup && (is_write || read_hit)) || fill_end;
      cache_hit  <= read_hit;
      cache_miss <= read_miss;
      if (read_hit) begin
        data_o <= cache_data[req_ptr];
      end else if (fill_end) begin
        // The last word is still in flight from the array on this cycle.
        data_o <= (req_off == word_cnt) ? array_rdata : cache_data[req_ptr];
      end
    end
  end

endmodule

// File: tb/tb_user_flash_cached.sv
// ---------------------------------------------------------------------------
// tb_user_flash_cached
//   Self-checking bench for user_flash_cached at the default geometry.
//   A behavioural model (flat word memory plus the set of resident lines)
//   predicts latency, hit/miss strobes and read data for every request; a
//   negedge monitor compares the DUT outputs against it on every cycle.
// ---------------------------------------------------------------------------
module tb_user_flash_cached;

  localparam int AW        = 17;
  localparam int LINES     = 16;
  localparam int WPL       = 4;
  localparam int LAT       = 4;
  localparam int MISS_LAT  = WPL * LAT + 1;
  localparam int MEM_WORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          select;
  logic [3:0]    wstrb;
  logic [AW-1:0] addr;
  logic [31:0]   data_i;
  logic          cache_flush;
  logic          ready;
  logic [31:0]   data_o;
  logic          cache_hit;
  logic          cache_miss;

  user_flash_cached #(
    .ADDR_WIDTH     (AW),
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL),
    .FLASH_LATENCY  (LAT),
    .WRITABLE       (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .select      (select),
    .wstrb       (wstrb),
    .addr        (addr),
    .data_i      (data_i),
    .cache_flush (cache_flush),
    .ready       (ready),
    .data_o      (data_o),
    .cache_hit   (cache_hit),
    .cache_miss  (cache_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [31:0] mem_model [MEM_WORDS];
  int          resident  [LINES];

  int          e0 = -1000;
  int          exp_lat = 0;
  bit          exp_hit = 1'b0;
  bit          exp_miss = 1'b0;
  bit          exp_write = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] model_data = '0;
  int          pulses = 0;
  int          seen_lat = -1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    bit exp_r, exp_h, exp_m;
    if (!reset_n) begin
      model_data = '0;
      check_output("reset_ready", {31'b0, ready}, 32'd0);
      check_output("reset_hit", {31'b0, cache_hit}, 32'd0);
      check_output("reset_miss", {31'b0, cache_miss}, 32'd0);
      check_output("reset_data", data_o, 32'd0);
    end else begin
      exp_r = (edge_cnt == e0 + exp_lat);
      exp_h = exp_r && exp_hit;
      exp_m = exp_miss && (edge_cnt == e0 + 1);
      if (exp_r && !exp_write) model_data = exp_data;
      check_output("ready", {31'b0, ready}, {31'b0, exp_r});
      check_output("cache_hit", {31'b0, cache_hit}, {31'b0, exp_h});
      check_output("cache_miss", {31'b0, cache_miss}, {31'b0, exp_m});
      check_output("data_o", data_o, model_data);
      if (ready === 1'b1) begin
        pulses++;
        seen_lat = edge_cnt - e0;
      end
    end
  end

  // One bus request. flush_at / drop_at are edge numbers relative to the
  // edge that samples select (edge 0); -1 disables them.
  task automatic apply_stimulus(input logic [AW-1:0] a, input logic [3:0] s,
                                input logic [31:0] d, input int flush_at,
                                input int drop_at);
    int word, line, idx;
    bit write, hit;
    word  = int'(a >> 2);
    line  = word / WPL;
    idx   = line % LINES;
    write = (s != 4'b0000);
    hit   = !write && (resident[idx] == line) && (flush_at != 0) && (flush_at != 1);

    @(posedge clk); #1;
    e0        = edge_cnt + 1;
    exp_lat   = (write || hit) ? 1 : MISS_LAT;
    exp_hit   = hit;
    exp_miss  = !write && !hit;
    exp_write = write;
    exp_data  = mem_model[word];
    pulses    = 0;
    seen_lat  = -1;
    select    = 1'b1;
    addr      = a;
    wstrb     = s;
    data_i    = d;

    for (int e = 0; e <= exp_lat; e++) begin
      cache_flush = (e == flush_at);
      if (drop_at >= 0 && e >= drop_at) select = 1'b0;
      @(posedge clk); #1;
    end
    cache_flush = 1'b0;
    @(posedge clk); #1;
    select = 1'b0;
    wstrb  = 4'b0000;

    if (write) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mem_model[word][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (flush_at >= 0) begin
      for (int i = 0; i < LINES; i++) resident[i] = -1;
    end
    if (!write && !hit && !(flush_at >= 2 && flush_at <= exp_lat)) resident[idx] = line;

    repeat (2) @(posedge clk);
    #1;
    check_output("ready_pulses", 32'(pulses), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_model[i] = '0;
    for (int i = 0; i < LINES; i++) resident[i] = -1;
    reset_n     = 1'b0;
    select      = 1'b0;
    wstrb       = 4'b0000;
    addr        = '0;
    data_i      = '0;
    cache_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] write 0x40 then read back through a miss and a hit");
    apply_stimulus(17'h040, 4'hF, 32'hDEADBEEF, -1, -1);
    check_output("write_latency", 32'(seen_lat), 32'd1);
    apply_stimulus(17'h040, 4'h0, 32'h0, -1, -1);
    check_output("miss_latency", 32'(seen_lat), 32'd17);
    check_output("read_0x40", data_o, 32'hDEADBEEF);
    apply_stimulus(17'h044, 4'h0, 32'h0, -1, -1);
    check_output("hit_latency", 32'(seen_lat), 32'd1);
    check_output("read_0x44", data_o, 32'h0);

    $display("[TB] byte-merge write-through into a cached word");
    apply_stimulus(17'h040, 4'b0010, 32'h0000AA00, -1, -1);
    apply_stimulus(17'h040, 4'h0, 32'h0, -1, -1);
    check_output("merge_hit_latency", 32'(seen_lat), 32'd1);
    check_output("read_merged", data_o, 32'hDEADAAEF);

    $display("[TB] conflicting tags on one index");
    apply_stimulus(17'h140, 4'hF, 32'h12345678, -1, -1);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(17'h140, 4'h0, 32'h0, -1, -1);
      check_output("conflict_0x140_latency", 32'(seen_lat), 32'd17);
      check_output("conflict_0x140_data", data_o, 32'h12345678);
      apply_stimulus(17'h040, 4'h0, 32'h0, -1, -1);
      check_output("conflict_0x40_latency", 32'(seen_lat), 32'd17);
      check_output("conflict_0x40_data", data_o, 32'hDEADAAEF);
    end

    $display("[TB] flush during a fill and alongside a lookup");
    apply_stimulus(17'h080, 4'hF, 32'hCAFEF00D, -1, -1);
    apply_stimulus(17'h080, 4'h0, 32'h0, 5, -1);
    check_output("flush_fill_data", data_o, 32'hCAFEF00D);
    apply_stimulus(17'h080, 4'h0, 32'h0, -1, -1);
    check_output("reread_after_flush_latency", 32'(seen_lat), 32'd17);
    apply_stimulus(17'h080, 4'h0, 32'h0, 0, -1);
    check_output("flush_with_lookup_latency", 32'(seen_lat), 32'd17);

    $display("[TB] select dropped during fill");
    apply_stimulus(17'h040, 4'h0, 32'h0, -1, 3);
    check_output("drop_select_data", data_o, 32'hDEADAAEF);

    $display("[TB] partial strobes on a cached word");
    apply_stimulus(17'h044, 4'b1001, 32'h11223344, -1, -1);
    apply_stimulus(17'h044, 4'h0, 32'h0, -1, -1);
    check_output("strobe_1001_hit_latency", 32'(seen_lat), 32'd1);
    check_output("strobe_1001_data", data_o, 32'h11000044);

    $display("[TB] reset in the middle of a fill");
    apply_stimulus(17'h100, 4'hF, 32'h0BADC0DE, -1, -1);
    @(posedge clk); #1;
    e0        = edge_cnt + 1;
    exp_lat   = MISS_LAT;
    exp_hit   = 1'b0;
    exp_miss  = 1'b1;
    exp_write = 1'b0;
    pulses    = 0;
    select    = 1'b1;
    addr      = 17'h100;
    wstrb     = 4'h0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    e0      = -1000;
    select  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < LINES; i++) resident[i] = -1;
    check_output("aborted_fill_pulses", 32'(pulses), 32'd0);
    repeat (2) @(posedge clk);
    apply_stimulus(17'h100, 4'h0, 32'h0, -1, -1);
    check_output("after_reset_latency", 32'(seen_lat), 32'd17);
    check_output("after_reset_data", data_o, 32'h0BADC0DE);
    apply_stimulus(17'h044, 4'h0, 32'h0, -1, -1);
    check_output("array_survives_reset", data_o, 32'h11000044);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
